// File: rtl/leaf_echo_if.sv
// BFT leaf link bundle: inbound packet, outbound packet and the resend backpressure line.
// The master side is the BFT switch; the slave side is the leaf.
interface leaf_echo_if #(
    parameter int unsigned PACKET_BITS = 49
);
    logic [PACKET_BITS-1:0] din_leaf_bft2interface;
    logic [PACKET_BITS-1:0] dout_leaf_interface2bft;
    logic                   resend;

    modport master (
        output din_leaf_bft2interface,
        output resend,
        input  dout_leaf_interface2bft
    );

    modport slave (
        input  din_leaf_bft2interface,
        input  resend,
        output dout_leaf_interface2bft
    );
endinterface

// File: rtl/leaf_echo.sv
// BFT echo leaf: buffers inbound data packets in a FIFO and re-emits them toward a
// programmable destination leaf/port, honouring resend backpressure.
// Packets on port 0 are configuration writes (addr 0 = dest leaf, addr 1 = dest port).
// Optional feature macro: LEAF_ECHO_CNT_EN adds accepted/dropped packet counters.
module leaf_echo #(
    parameter int unsigned PACKET_BITS       = 49,
    parameter int unsigned PAYLOAD_BITS      = 32,
    parameter int unsigned NUM_LEAF_BITS     = 5,
    parameter int unsigned NUM_PORT_BITS     = 4,
    parameter int unsigned NUM_ADDR_BITS     = 7,
    parameter int unsigned FIFO_DEPTH_BITS   = 4,
    parameter int unsigned DEFAULT_DEST_LEAF = 0,
    parameter int unsigned DEFAULT_DEST_PORT = 1,
    parameter int unsigned CNT_BITS          = 16
) (
    input  logic              clk_bft,
    input  logic              reset_bft,
    leaf_echo_if.slave        bft
`ifdef LEAF_ECHO_CNT_EN
    ,
    output logic [CNT_BITS-1:0] pkt_in_cnt,
    output logic [CNT_BITS-1:0] pkt_drop_cnt
`endif
);

    localparam int unsigned Depth    = 1 << FIFO_DEPTH_BITS;
    localparam int unsigned ValidBit = PACKET_BITS - 1;
    localparam int unsigned LeafLsb  = ValidBit - NUM_LEAF_BITS;
    localparam int unsigned PortLsb  = LeafLsb - NUM_PORT_BITS;
    localparam int unsigned AddrLsb  = PortLsb - NUM_ADDR_BITS;

    localparam logic [NUM_ADDR_BITS-1:0] AddrDestLeaf = '0;
    localparam logic [NUM_ADDR_BITS-1:0] AddrDestPort = {{(NUM_ADDR_BITS-1){1'b0}}, 1'b1};

    // Inbound field decode
    logic                     din_valid;
    logic [NUM_PORT_BITS-1:0] din_port;
    logic [NUM_ADDR_BITS-1:0] din_addr;
    logic [PAYLOAD_BITS-1:0]  din_payload;

    assign din_valid   = bft.din_leaf_bft2interface[ValidBit];
    assign din_port    = bft.din_leaf_bft2interface[PortLsb +: NUM_PORT_BITS];
    assign din_addr    = bft.din_leaf_bft2interface[AddrLsb +: NUM_ADDR_BITS];
    assign din_payload = bft.din_leaf_bft2interface[PAYLOAD_BITS-1:0];

    // State
    logic [NUM_LEAF_BITS-1:0]   dest_leaf_q, dest_leaf_d;
    logic [NUM_PORT_BITS-1:0]   dest_port_q, dest_port_d;
    logic [FIFO_DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
    // One extra bit so the count can represent a completely full FIFO.
    logic [FIFO_DEPTH_BITS:0]   count_q, count_d;
    logic [PACKET_BITS-1:0]     dout_q, dout_d;
    logic [PACKET_BITS-1:0]     mem_q [Depth];

    logic                       is_cfg, is_data;
    logic                       fifo_empty, fifo_full;
    logic                       slot_free, push, pop;
    logic [PACKET_BITS-1:0]     push_pkt;

    assign bft.dout_leaf_interface2bft = dout_q;

    // Classification, FIFO handshake and next-state computation
    always_comb begin
        is_cfg      = din_valid && (din_port == '0);
        is_data     = din_valid && (din_port != '0);
        fifo_empty  = (count_q == '0);
        // count never exceeds Depth, so its top bit alone flags full.
        fifo_full   = count_q[FIFO_DEPTH_BITS];
        // Resend only matters while a valid packet is actually presented.
        slot_free   = !dout_q[ValidBit] || !bft.resend;
        pop         = slot_free && !fifo_empty;
        push        = is_data && (!fifo_full || pop);
        push_pkt    = {1'b1, dest_leaf_q, dest_port_q, din_addr, din_payload};

        dest_leaf_d = dest_leaf_q;
        dest_port_d = dest_port_q;
        if (is_cfg) begin
            if (din_addr == AddrDestLeaf) begin
                dest_leaf_d = din_payload[NUM_LEAF_BITS-1:0];
            end else if (din_addr == AddrDestPort) begin
                dest_port_d = din_payload[NUM_PORT_BITS-1:0];
            end
        end

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        dout_d = dout_q;
        if (slot_free) begin
            dout_d = pop ? mem_q[rd_ptr_q] : '0;
        end
    end

    // Control and output registers with synchronous reset
    always_ff @(posedge clk_bft) begin
        if (reset_bft) begin
            dest_leaf_q <= NUM_LEAF_BITS'(DEFAULT_DEST_LEAF);
            dest_port_q <= NUM_PORT_BITS'(DEFAULT_DEST_PORT);
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            dout_q      <= '0;
        end else begin
            dest_leaf_q <= dest_leaf_d;
            dest_port_q <= dest_port_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            dout_q      <= dout_d;
        end
    end

    // FIFO storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk_bft) begin
        if (push && !reset_bft) begin
            mem_q[wr_ptr_q] <= push_pkt;
        end
    end

`ifdef LEAF_ECHO_CNT_EN
    logic [CNT_BITS-1:0] in_cnt_q, drop_cnt_q;
    logic                drop;

    assign drop         = is_data && !push;
    assign pkt_in_cnt   = in_cnt_q;
    assign pkt_drop_cnt = drop_cnt_q;

    // Accepted/dropped data packet counters, free-running with wrap
    always_ff @(posedge clk_bft) begin
        if (reset_bft) begin
            in_cnt_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (push) in_cnt_q   <= in_cnt_q + 1'b1;
            if (drop) drop_cnt_q <= drop_cnt_q + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_leaf_echo.sv
// Directed bench for leaf_echo: latency, config writes, resend hold, full/drop,
// push+pop on a full FIFO across pointer wrap, and mid-operation reset.
module tb_leaf_echo;

    localparam int unsigned PacketBits = 49;
    localparam int unsigned CntBits    = 16;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    leaf_echo_if #(.PACKET_BITS(PacketBits)) bus ();

`ifdef LEAF_ECHO_CNT_EN
    logic [CntBits-1:0] in_cnt;
    logic [CntBits-1:0] drop_cnt;
`endif

    leaf_echo dut (
        .clk_bft   (clk),
        .reset_bft (rst),
        .bft       (bus.slave)
`ifdef LEAF_ECHO_CNT_EN
        ,
        .pkt_in_cnt  (in_cnt),
        .pkt_drop_cnt(drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs are driven and outputs sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [PacketBits-1:0] mk_in(input logic [3:0] port, input logic [6:0] addr,
                                                    input logic [31:0] payload);
        return {1'b1, 5'd0, port, addr, payload};
    endfunction

    function automatic logic [PacketBits-1:0] mk_out(input logic [4:0] leaf, input logic [3:0] port,
                                                     input logic [6:0] addr, input logic [31:0] payload);
        return {1'b1, leaf, port, addr, payload};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        bus.din_leaf_bft2interface = '0;
        bus.resend = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    logic [PacketBits-1:0] expq[$];
    logic [PacketBits-1:0] e;

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        bus.din_leaf_bft2interface = '0;
        bus.resend = 1'b0;
        #1;
        do_reset();
        check_val("reset_dout", bus.dout_leaf_interface2bft, '0);
`ifdef LEAF_ECHO_CNT_EN
        check_val("reset_in_cnt", in_cnt, '0);
        check_val("reset_drop_cnt", drop_cnt, '0);
`endif

        // 1) single packet latency
        bus.din_leaf_bft2interface = mk_in(4'd2, 7'd5, 32'hDEADBEEF);
        step();
        bus.din_leaf_bft2interface = '0;
        check_val("t1_edge0", bus.dout_leaf_interface2bft, '0);
        step();
        check_val("t1_edge1", bus.dout_leaf_interface2bft, mk_out(5'd0, 4'd1, 7'd5, 32'hDEADBEEF));
        step();
        check_val("t1_edge2", bus.dout_leaf_interface2bft, '0);

        // 2) config writes, then data uses the new destination
        bus.din_leaf_bft2interface = mk_in(4'd0, 7'd0, 32'd7);
        step();
        check_val("t2_cfg_leaf", bus.dout_leaf_interface2bft, '0);
        bus.din_leaf_bft2interface = mk_in(4'd0, 7'd1, 32'd3);
        step();
        check_val("t2_cfg_port", bus.dout_leaf_interface2bft, '0);
        bus.din_leaf_bft2interface = mk_in(4'd2, 7'd9, 32'h11);
        step();
        bus.din_leaf_bft2interface = '0;
        check_val("t2_no_cfg_echo", bus.dout_leaf_interface2bft, '0);
        step();
        check_val("t2_echo", bus.dout_leaf_interface2bft, mk_out(5'd7, 4'd3, 7'd9, 32'h11));
        step();
        check_val("t2_idle", bus.dout_leaf_interface2bft, '0);

        // 3) resend hold for 4 cycles
        bus.din_leaf_bft2interface = mk_in(4'd5, 7'd1, 32'hA);
        step();
        bus.din_leaf_bft2interface = mk_in(4'd5, 7'd2, 32'hB);
        step();
        bus.din_leaf_bft2interface = '0;
        check_val("t3_first", bus.dout_leaf_interface2bft, mk_out(5'd7, 4'd3, 7'd1, 32'hA));
        bus.resend = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check_val("t3_hold", bus.dout_leaf_interface2bft, mk_out(5'd7, 4'd3, 7'd1, 32'hA));
        end
        bus.resend = 1'b0;
        step();
        check_val("t3_second", bus.dout_leaf_interface2bft, mk_out(5'd7, 4'd3, 7'd2, 32'hB));
        step();
        check_val("t3_idle", bus.dout_leaf_interface2bft, '0);

        // 4) fill under resend, drop on full; 5) push+pop on full across wrap
        do_reset();
        bus.resend = 1'b1;
        for (int i = 0; i < 17; i++) begin
            bus.din_leaf_bft2interface = mk_in(4'd2, 7'(i), 32'h1000 + i);
            step();
        end
        check_val("t4_dout_p0", bus.dout_leaf_interface2bft, mk_out(5'd0, 4'd1, 7'd0, 32'h1000));
        bus.din_leaf_bft2interface = mk_in(4'd2, 7'd17, 32'h1000 + 17);
        step();
        check_val("t4_drop_hold", bus.dout_leaf_interface2bft, mk_out(5'd0, 4'd1, 7'd0, 32'h1000));
`ifdef LEAF_ECHO_CNT_EN
        check_val("t4_drop_cnt", drop_cnt, 16'd1);
        check_val("t4_in_cnt", in_cnt, 16'd17);
`endif
        expq.delete();
        for (int i = 1; i < 17; i++) expq.push_back(mk_out(5'd0, 4'd1, 7'(i), 32'h1000 + i));
        bus.resend = 1'b0;
        for (int j = 0; j < 4; j++) begin
            bus.din_leaf_bft2interface = mk_in(4'd3, 7'(40 + j), 32'h2000 + j);
            expq.push_back(mk_out(5'd0, 4'd1, 7'(40 + j), 32'h2000 + j));
            step();
            e = expq.pop_front();
            check_val("t5_pushpop", bus.dout_leaf_interface2bft, e);
        end
        bus.din_leaf_bft2interface = '0;
        for (int k = 0; k < 18; k++) begin
            step();
            e = (expq.size() > 0) ? expq.pop_front() : '0;
            check_val("t5_drain", bus.dout_leaf_interface2bft, e);
        end
`ifdef LEAF_ECHO_CNT_EN
        check_val("t5_in_cnt", in_cnt, 16'd21);
        check_val("t5_drop_cnt", drop_cnt, 16'd1);
`endif

        // 6) reset with packets buffered
        bus.din_leaf_bft2interface = mk_in(4'd0, 7'd0, 32'd9);
        step();
        bus.din_leaf_bft2interface = mk_in(4'd0, 7'd1, 32'd5);
        step();
        bus.resend = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.din_leaf_bft2interface = mk_in(4'd6, 7'(60 + i), 32'h3000 + i);
            step();
        end
        bus.din_leaf_bft2interface = '0;
        step();
        check_val("t6_pre_reset", bus.dout_leaf_interface2bft, mk_out(5'd9, 4'd5, 7'd60, 32'h3000));
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.resend = 1'b0;
        check_val("t6_reset_dout", bus.dout_leaf_interface2bft, '0);
`ifdef LEAF_ECHO_CNT_EN
        check_val("t6_in_cnt", in_cnt, '0);
        check_val("t6_drop_cnt", drop_cnt, '0);
`endif
        for (int i = 0; i < 20; i++) begin
            step();
            check_val("t6_quiet", bus.dout_leaf_interface2bft, '0);
        end
        bus.din_leaf_bft2interface = mk_in(4'd4, 7'd3, 32'hCAFE);
        step();
        bus.din_leaf_bft2interface = '0;
        step();
        check_val("t6_default_dest", bus.dout_leaf_interface2bft, mk_out(5'd0, 4'd1, 7'd3, 32'hCAFE));
        step();
        check_val("t6_idle", bus.dout_leaf_interface2bft, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
